dice_round_judge: RTL and testbench
===================================

// Module: dice_round_judge
// PURPOSE
// - Downstream of the dice roller: consumes each player's settled die value and finish pulse.
// - Decides each round (P1 win / P2 win / tie), keeps match scores and holds the round result for display.
// - Declares the match winner at WIN_SCORE and gates further rolling until a new game starts.
// - Outputs feed the 7-seg scan (scores), the LED matrix and the RGB LEDs (result/winner).
// PARAMETERS
// - WIN_SCORE    default 3    round wins needed to take the match (1..15)
// - RESULT_HOLD  default 500  cycles result_valid stays high after a round is judged (>=1)
// - HOLD_W       default 10   width of hold counter; must satisfy 2**HOLD_W > RESULT_HOLD
// PORTS
// - clk           in   1  system clock
// - rst           in   1  reset, asynchronous, active-high
// - finish1       in   1  one-cycle pulse: player 1 die settled, dice1 valid this cycle
// - finish2       in   1  one-cycle pulse: player 2 die settled, dice2 valid this cycle
// - dice1         in   4  player 1 die value, legal 1..6
// - dice2         in   4  player 2 die value, legal 1..6
// - new_game      in   1  one-cycle pulse: clear scores and round count, start a new match
// - roll_enable   out  1  1 = roller may accept start1/start2
// - score1        out  4  player 1 round wins
// - score2        out  4  player 2 round wins
// - round_cnt     out  4  rounds judged this match, saturates at 15
// - round_result  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 tie or void
// - result_valid  out  1  high while a round result is displayed
// - match_winner  out  2  00 none, 01 P1, 10 P2
// BEHAVIOUR
// - Reset values: state WAIT, scores 0, round_cnt 0, round_result 00, result_valid 0, match_winner 00, roll_enable 1.
//   Latches and got-flags are cleared; asserting rst mid-operation aborts at once.
// - FSM: WAIT -> JUDGE -> SHOW -> (WAIT | OVER); OVER -> WAIT on new_game only.
// - WAIT:
//   - finishN latches diceN and sets gotN.
//   - The first pulse per player per round is kept; repeats are ignored.
//   - finish1 and finish2 in the same cycle are both latched.
//   - Once got1 and got2 are both set, go to JUDGE next cycle.
// - JUDGE (1 cycle):
//   - Either latched value outside 1..6 -> result 11 (void), no score change.
//   - Otherwise: higher value wins (01/10) and that score increments; equal values -> 11, no change.
//   - round_cnt increments, saturating at 15. Clear got1/got2.
// - Latency: second finish sampled at cycle t -> JUDGE at t+1 -> outputs updated and result_valid=1 from t+2.
// - SHOW:
//   - result_valid=1 and roll_enable=0 for exactly RESULT_HOLD cycles.
//   - Afterwards: if score1 or score2 == WIN_SCORE, go to OVER and set match_winner; else go to WAIT.
//   - On leaving SHOW: result_valid=0, round_result is held until the next JUDGE.
// - OVER: roll_enable=0, finish pulses ignored, scores and match_winner held.
// - new_game (any state):
//   - Clears scores, round_cnt, round_result, match_winner and got-flags; result_valid=0; goes to WAIT next cycle.
//   - Takes priority over a finish pulse in the same cycle (that finish is discarded).
// - Scores never exceed WIN_SCORE; at most one score increments per round.
// - Finish pulses arriving during JUDGE or SHOW are discarded, not queued.
// STRUCTURE
// - Shared include dice_defs.vh holds:
//   - result codes (RES_NONE/P1/P2/TIE)
//   - winner codes
//   - FSM state encodings
//   - DICE_MIN=1, DICE_MAX=6
// - One natural sub-module: dice_hold_timer (load on JUDGE exit, counts RESULT_HOLD cycles, done pulse).
// - Everything else lives in a single FSM plus datapath; all outputs are registered.
// TESTING
// - Reset: rst pulse mid-SHOW -> all outputs reach reset values immediately; roll_enable=1.
// - Normal round: finish1 with dice1=5, then 3 cycles later finish2 with dice2=2
//   -> round_result=01, score1=1, result_valid high 500 cycles starting 2 cycles after finish2.
// - Tie and simultaneous finish: finish1 and finish2 same cycle, both dice=4
//   -> round_result=11, scores unchanged, round_cnt=1.
// - Void and duplicates: dice1=0 -> result 11, no score change.
//   - A second finish1 (dice1=6) before finish2 is ignored; the first value is used.
// - Match end: P2 wins 3 rounds (WIN_SCORE=3)
//   -> after the 3rd SHOW: match_winner=10, roll_enable=0.
//   - Further finish pulses have no effect.
//   - new_game -> scores 0, match_winner 00, roll_enable=1 next cycle.
// - Priority: new_game and finish2 in the same cycle during WAIT with got1 set
//   -> no JUDGE, got-flags cleared, scores 0.

Source files
------------

// File: rtl/dice_round_judge_pkg.sv
// ============================================================================
// Module      : dice_round_judge_pkg
// Description : Shared result/winner codes, FSM state encoding and die range
//               for the dice round judge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dice_round_judge_pkg;

    // Round result codes
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;  // tie or void round

    // Match winner codes
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Legal die face range
    localparam logic [3:0] DICE_MIN = 4'd1;
    localparam logic [3:0] DICE_MAX = 4'd6;

    // Judge FSM states
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_JUDGE = 2'd1,
        ST_SHOW  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // True when a latched die value is a real face
    function automatic logic die_legal(input logic [3:0] v);
        return (v >= DICE_MIN) && (v <= DICE_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dice_hold_timer.sv
// ============================================================================
// Module      : dice_hold_timer
// Description : Counts RESULT_HOLD cycles after a load; done is high during
//               the final counted cycle so the caller can leave on that edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dice_hold_timer #(
    parameter int RESULT_HOLD = 500,
    parameter int HOLD_W      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    output logic done_o
);

    localparam logic [HOLD_W-1:0] LOAD_VAL = HOLD_W'(RESULT_HOLD - 1);

    logic [HOLD_W-1:0] cnt_q;
    logic              busy_q;

    assign done_o = busy_q && (cnt_q == '0);

    // Down-counter: loaded while the judge evaluates, runs through the show window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (load_i) begin
            cnt_q  <= LOAD_VAL;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dice_round_judge.sv
// ============================================================================
// Module      : dice_round_judge
// Description : Collects both players' settled dice, judges each round, keeps
//               match scores, holds the result for display and declares the
//               match winner. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dice_round_judge
    import dice_round_judge_pkg::*;
#(
    parameter int WIN_SCORE   = 3,
    parameter int RESULT_HOLD = 500,
    parameter int HOLD_W      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       finish1,
    input  logic       finish2,
    input  logic [3:0] dice1,
    input  logic [3:0] dice2,
    input  logic       new_game,
    output logic       roll_enable,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] round_cnt,
    output logic [1:0] round_result,
    output logic       result_valid,
    output logic [1:0] match_winner
);

    localparam logic [3:0] WIN_VAL = 4'(WIN_SCORE);

    state_t     state_q;
    logic       got1_q, got2_q;
    logic [3:0] die1_q, die2_q;
    logic [3:0] score1_q, score2_q, round_cnt_q;
    logic [1:0] result_q, winner_q;
    logic       valid_q, roll_en_q;

    logic       got1_d, got2_d;
    logic [1:0] verdict_d;
    logic       hold_done;

    assign roll_enable  = roll_en_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign round_cnt    = round_cnt_q;
    assign round_result = result_q;
    assign result_valid = valid_q;
    assign match_winner = winner_q;

    // A player counts as "in" for this round once any finish has been seen
    assign got1_d = got1_q | finish1;
    assign got2_d = got2_q | finish2;

    // Round verdict from the latched dice; any illegal face voids the round
    always_comb begin
        verdict_d = RES_TIE;
        if (die_legal(die1_q) && die_legal(die2_q)) begin
            if (die1_q > die2_q) begin
                verdict_d = RES_P1;
            end else if (die2_q > die1_q) begin
                verdict_d = RES_P2;
            end
        end
    end

    dice_hold_timer #(
        .RESULT_HOLD (RESULT_HOLD),
        .HOLD_W      (HOLD_W)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (new_game),
        .load_i (state_q == ST_JUDGE),
        .done_o (hold_done)
    );

    // Judge FSM with its datapath; new_game overrides everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            got1_q      <= 1'b0;
            got2_q      <= 1'b0;
            die1_q      <= '0;
            die2_q      <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            round_cnt_q <= '0;
            result_q    <= RES_NONE;
            winner_q    <= WIN_NONE;
            valid_q     <= 1'b0;
            roll_en_q   <= 1'b1;
        end else if (new_game) begin
            state_q     <= ST_WAIT;
            got1_q      <= 1'b0;
            got2_q      <= 1'b0;
            score1_q    <= '0;
            score2_q    <= '0;
            round_cnt_q <= '0;
            result_q    <= RES_NONE;
            winner_q    <= WIN_NONE;
            valid_q     <= 1'b0;
            roll_en_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    // Only the first settle per player per round is kept
                    if (finish1 && !got1_q) begin
                        got1_q <= 1'b1;
                        die1_q <= dice1;
                    end
                    if (finish2 && !got2_q) begin
                        got2_q <= 1'b1;
                        die2_q <= dice2;
                    end
                    if (got1_d && got2_d) begin
                        state_q   <= ST_JUDGE;
                        roll_en_q <= 1'b0;
                    end
                end
                ST_JUDGE: begin
                    result_q <= verdict_d;
                    if (verdict_d == RES_P1 && score1_q < WIN_VAL) begin
                        score1_q <= score1_q + 1'b1;
                    end
                    if (verdict_d == RES_P2 && score2_q < WIN_VAL) begin
                        score2_q <= score2_q + 1'b1;
                    end
                    if (round_cnt_q != 4'd15) begin
                        round_cnt_q <= round_cnt_q + 1'b1;
                    end
                    got1_q    <= 1'b0;
                    got2_q    <= 1'b0;
                    valid_q   <= 1'b1;
                    roll_en_q <= 1'b0;
                    state_q   <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (hold_done) begin
                        valid_q <= 1'b0;
                        if (score1_q == WIN_VAL || score2_q == WIN_VAL) begin
                            state_q   <= ST_OVER;
                            winner_q  <= (score1_q == WIN_VAL) ? WIN_P1 : WIN_P2;
                            roll_en_q <= 1'b0;
                        end else begin
                            state_q   <= ST_WAIT;
                            roll_en_q <= 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    roll_en_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dice_round_judge.sv
// ============================================================================
// Module      : tb_dice_round_judge
// Description : Scoreboard bench for dice_round_judge. Stimulus pushes the
//               hand-computed round outcome; a monitor pops it when
//               result_valid rises and also times the hold window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dice_round_judge;

    localparam int WIN_SCORE   = 3;
    localparam int RESULT_HOLD = 500;
    localparam int HOLD_W      = 10;

    logic       clk;
    logic       rst;
    logic       finish1, finish2, new_game;
    logic [3:0] dice1, dice2;
    logic       roll_enable, result_valid;
    logic [3:0] score1, score2, round_cnt;
    logic [1:0] round_result, match_winner;

    typedef struct {
        logic [1:0] res;
        int         s1;
        int         s2;
        int         rc;
        int         when;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_set_cyc = 0;
    int hi_cnt = 0;
    logic prev_rv = 1'b0;

    dice_round_judge #(
        .WIN_SCORE   (WIN_SCORE),
        .RESULT_HOLD (RESULT_HOLD),
        .HOLD_W      (HOLD_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .finish1      (finish1),
        .finish2      (finish2),
        .dice1        (dice1),
        .dice2        (dice2),
        .new_game     (new_game),
        .roll_enable  (roll_enable),
        .score1       (score1),
        .score2       (score2),
        .round_cnt    (round_cnt),
        .round_result (round_result),
        .result_valid (result_valid),
        .match_winner (match_winner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One-cycle input pulse; records the cycle the inputs were set in
    task automatic pulse(input logic f1, input logic [3:0] d1, input logic f2,
                         input logic [3:0] d2, input logic ng);
        @(posedge clk); #1;
        finish1 = f1; dice1 = d1; finish2 = f2; dice2 = d2; new_game = ng;
        last_set_cyc = cyc;
        @(posedge clk); #1;
        finish1 = 1'b0; finish2 = 1'b0; new_game = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] res, input int s1, input int s2, input int rc);
        exp_t e;
        e.res = res; e.s1 = s1; e.s2 = s2; e.rc = rc;
        e.when = last_set_cyc + 2;
        q.push_back(e);
    endtask

    // Bounded wait for a complete show window
    task automatic wait_round();
        int n;
        n = 0;
        @(negedge clk);
        while (!result_valid && n < 50) begin @(negedge clk); n++; end
        if (!result_valid) chk("wait_rv_rise", 0, 1);
        n = 0;
        while (result_valid && n < RESULT_HOLD + 50) begin @(negedge clk); n++; end
        if (result_valid) chk("wait_rv_fall", 1, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_score1"}, score1, 0);
        chk({tag, "_score2"}, score2, 0);
        chk({tag, "_round_cnt"}, round_cnt, 0);
        chk({tag, "_round_result"}, round_result, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_match_winner"}, match_winner, 0);
        chk({tag, "_roll_enable"}, roll_enable, 1);
    endtask

    // Monitor: compare on each result_valid rise, time each show window
    always @(negedge clk) begin
        if (rst) begin
            prev_rv = 1'b0;
            hi_cnt  = 0;
        end else begin
            if (result_valid && !prev_rv) begin
                hi_cnt = 0;
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("sb_round_result", round_result, mon_e.res);
                    chk("sb_score1", score1, mon_e.s1);
                    chk("sb_score2", score2, mon_e.s2);
                    chk("sb_round_cnt", round_cnt, mon_e.rc);
                    chk("sb_latency_cycle", cyc, mon_e.when);
                    chk("sb_roll_enable_show", roll_enable, 0);
                end
            end
            if (result_valid) hi_cnt++;
            if (!result_valid && prev_rv) chk("sb_hold_len", hi_cnt, RESULT_HOLD);
            prev_rv = result_valid;
        end
    end

    initial begin
        rst = 1'b1;
        finish1 = 1'b0; finish2 = 1'b0; new_game = 1'b0;
        dice1 = 4'd0; dice2 = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        // Normal round: P1 5 vs P2 2, finish2 three cycles after finish1
        pulse(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        @(posedge clk); #1;
        pulse(1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
        push_exp(2'b01, 1, 0, 1);
        wait_round();
        chk("after_show_roll_enable", roll_enable, 1);
        chk("after_show_result_held", round_result, 1);

        // Simultaneous finish, tie 4/4
        pulse(1'b1, 4'd4, 1'b1, 4'd4, 1'b0);
        push_exp(2'b11, 1, 0, 2);
        wait_round();

        // Void round (dice1=0) with a duplicate finish1=6 ignored
        pulse(1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        pulse(1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
        pulse(1'b0, 4'd0, 1'b1, 4'd3, 1'b0);
        push_exp(2'b11, 1, 0, 3);
        wait_round();

        // Duplicate finish1=6 ignored, first value 2 loses to 4
        pulse(1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
        pulse(1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
        pulse(1'b0, 4'd0, 1'b1, 4'd4, 1'b0);
        push_exp(2'b10, 1, 1, 4);
        wait_round();

        // Asynchronous reset in the middle of a show window
        pulse(1'b1, 4'd3, 1'b1, 4'd1, 1'b0);
        push_exp(2'b01, 2, 1, 5);
        repeat (12) @(posedge clk);
        #1;
        chk("pre_reset_result_valid", result_valid, 1);
        rst = 1'b1;
        #1;
        check_reset_vals("midshow_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Match: P2 takes three straight rounds
        pulse(1'b1, 4'd1, 1'b1, 4'd6, 1'b0);
        push_exp(2'b10, 0, 1, 1);
        wait_round();
        pulse(1'b1, 4'd2, 1'b1, 4'd5, 1'b0);
        push_exp(2'b10, 0, 2, 2);
        wait_round();
        pulse(1'b1, 4'd3, 1'b1, 4'd4, 1'b0);
        push_exp(2'b10, 0, 3, 3);
        wait_round();
        chk("over_match_winner", match_winner, 2);
        chk("over_roll_enable", roll_enable, 0);
        chk("over_result_held", round_result, 2);

        // Finishes in OVER are ignored
        pulse(1'b1, 4'd6, 1'b1, 4'd1, 1'b0);
        repeat (10) @(negedge clk);
        chk("over_ignore_rv", result_valid, 0);
        chk("over_ignore_score1", score1, 0);
        chk("over_ignore_score2", score2, 3);
        chk("over_ignore_rc", round_cnt, 3);

        // New game clears the match
        pulse(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        check_reset_vals("new_game");

        // new_game beats finish2 while got1 is set
        pulse(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        pulse(1'b0, 4'd0, 1'b1, 4'd1, 1'b1);
        repeat (5) @(negedge clk);
        chk("prio_no_judge_rv", result_valid, 0);
        chk("prio_no_judge_rc", round_cnt, 0);
        pulse(1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
        repeat (5) @(negedge clk);
        chk("prio_got1_cleared_rv", result_valid, 0);
        pulse(1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
        push_exp(2'b01, 1, 0, 1);
        wait_round();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
